// File: rtl/calendar_day_counter.sv
// calendar_day_counter
//   Registered date generator: holds day of month, month and weekday and
//   advances them by one calendar day per qualified tick. Supports a
//   range-checked synchronous load and reports month/year rollover.
//
//   Optional feature macro: CALENDAR_LEAP_YEAR_EN
//     defined   -> 2-bit year-mod-4 phase register, Feb has 29 days at phase 0
//     undefined -> no phase register, Feb always 28 days, ymod_in ignored
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   tick       advance one day this cycle
//   load       load date_in/mon_in/week_in/ymod_in (priority over tick)
//   date_in    day of month to load (1..31)
//   mon_in     month to load (1..12)
//   week_in    weekday to load (0..6)
//   ymod_in    year-mod-4 phase to load (leap build only)
//   date_out   current day of month
//   mon_out    current month
//   week_out   current weekday
//   month_wrap one-cycle pulse when an advance changes the month
//   year_wrap  one-cycle pulse on Dec 31 -> Jan 1
//   err        one-cycle pulse when a load is rejected
module calendar_day_counter #(
  parameter int unsigned START_WEEK     = 0,
  parameter int unsigned YEAR_MOD4_INIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [4:0] date_in,
  input  logic [3:0] mon_in,
  input  logic [2:0] week_in,
  input  logic [1:0] ymod_in,
  output logic [4:0] date_out,
  output logic [3:0] mon_out,
  output logic [2:0] week_out,
  output logic       month_wrap,
  output logic       year_wrap,
  output logic       err
);

  // Day count of a month; illegal months return 0 so any date fails the check.
  function automatic logic [4:0] f_days(input logic [3:0] mon, input logic leap);
    logic [4:0] n;
    case (mon)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: n = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                     n = 5'd30;
      4'd2:                                        n = leap ? 5'd29 : 5'd28;
      default:                                     n = 5'd0;
    endcase
    return n;
  endfunction

  logic [4:0] r_date, w_date;
  logic [3:0] r_mon,  w_mon;
  logic [2:0] r_week, w_week;
  logic       r_mwrap, w_mwrap;
  logic       r_ywrap, w_ywrap;
  logic       r_err,   w_err;
  logic       w_leap_cur;
  logic       w_leap_in;
  logic       w_load_ok;

`ifdef CALENDAR_LEAP_YEAR_EN
  logic [1:0] r_ymod, w_ymod;
  assign w_leap_cur = (r_ymod == 2'd0);
  assign w_leap_in  = (ymod_in == 2'd0);
`else
  logic [1:0] w_unused_ymod;
  assign w_unused_ymod = ymod_in ^ 2'(YEAR_MOD4_INIT);
  assign w_leap_cur    = 1'b0;
  assign w_leap_in     = 1'b0;
`endif

  assign w_load_ok = (mon_in >= 4'd1) && (mon_in <= 4'd12) &&
                     (week_in <= 3'd6) &&
                     (date_in >= 5'd1) && (date_in <= f_days(mon_in, w_leap_in));

  always_comb begin
    w_date  = r_date;
    w_mon   = r_mon;
    w_week  = r_week;
    w_mwrap = 1'b0;
    w_ywrap = 1'b0;
    w_err   = 1'b0;
`ifdef CALENDAR_LEAP_YEAR_EN
    w_ymod  = r_ymod;
`endif
    if (load) begin
      if (w_load_ok) begin
        w_date = date_in;
        w_mon  = mon_in;
        w_week = week_in;
`ifdef CALENDAR_LEAP_YEAR_EN
        w_ymod = ymod_in;
`endif
      end else begin
        w_err = 1'b1;
      end
    end else if (tick) begin
      w_week = (r_week == 3'd6) ? 3'd0 : r_week + 3'd1;
      if (r_date < f_days(r_mon, w_leap_cur)) begin
        w_date = r_date + 5'd1;
      end else begin
        w_date  = 5'd1;
        w_mwrap = 1'b1;
        if (r_mon == 4'd12) begin
          w_mon   = 4'd1;
          w_ywrap = 1'b1;
`ifdef CALENDAR_LEAP_YEAR_EN
          w_ymod  = r_ymod + 2'd1;
`endif
        end else begin
          w_mon = r_mon + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_date  <= 5'd1;
      r_mon   <= 4'd1;
      r_week  <= 3'(START_WEEK);
      r_mwrap <= 1'b0;
      r_ywrap <= 1'b0;
      r_err   <= 1'b0;
`ifdef CALENDAR_LEAP_YEAR_EN
      r_ymod  <= 2'(YEAR_MOD4_INIT);
`endif
    end else begin
      r_date  <= w_date;
      r_mon   <= w_mon;
      r_week  <= w_week;
      r_mwrap <= w_mwrap;
      r_ywrap <= w_ywrap;
      r_err   <= w_err;
`ifdef CALENDAR_LEAP_YEAR_EN
      r_ymod  <= w_ymod;
`endif
    end
  end

  assign date_out   = r_date;
  assign mon_out    = r_mon;
  assign week_out   = r_week;
  assign month_wrap = r_mwrap;
  assign year_wrap  = r_ywrap;
  assign err        = r_err;

endmodule

// File: doc/calendar_day_counter.md
# calendar_day_counter

Sequential date generator that holds the current day of month, month and weekday, and advances them by one calendar day per qualified tick. It sits directly upstream of the week-teller stage and drives its date, month and weekday inputs with values that are always legal. It also supports a synchronous load of a new date, with range checking, and reports month and year rollover.

## Interface
Parameters:
- `START_WEEK`, default 0: weekday loaded at reset (0..6).
- `YEAR_MOD4_INIT`, default 1: year-mod-4 phase loaded at reset. 0 means a leap year.

Ports:
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `tick`, input, 1: advance one day on this cycle.
- `load`, input, 1: request to load `date_in` / `mon_in` / `week_in` / `ymod_in`.
- `date_in`, input, 5: day of month to load (1..31).
- `mon_in`, input, 4: month to load (1..12).
- `week_in`, input, 3: weekday to load (0..6).
- `ymod_in`, input, 2: year-mod-4 phase to load. Ignored when the leap feature is compiled out.
- `date_out`, output, 5: current day of month.
- `mon_out`, output, 4: current month.
- `week_out`, output, 3: current weekday.
- `month_wrap`, output, 1: one-cycle pulse when an advance changes the month.
- `year_wrap`, output, 1: one-cycle pulse when an advance goes from Dec 31 to Jan 1.
- `err`, output, 1: one-cycle pulse when a load is rejected.

## Operation
- Reset values: `date_out`=1, `mon_out`=1, `week_out`=`START_WEEK`, internal year phase=`YEAR_MOD4_INIT`, and `month_wrap`/`year_wrap`/`err`=0.
- Days in month:
  - 31 for months 1, 3, 5, 7, 8, 10 and 12.
  - 30 for months 4, 6, 9 and 11.
  - Feb is 28, or 29 when the leap feature is enabled and the year phase is 0.
- Advance (`tick`=1, `load`=0):
  - When `date_out` is below the month's day count, `date_out` increments.
  - Otherwise `date_out` becomes 1, `mon_out` increments and `month_wrap` pulses.
  - When `mon_out` was 12, `mon_out` becomes 1, `year_wrap` also pulses, and the year phase increments modulo 4 (the 3→0 wrap is legal).
- Weekday on every advance: `week_out` increments, with 6→0.
- Load (`load`=1) is valid when all of the following hold:
  - `mon_in` is in 1..12.
  - `week_in` is 7 or less minus one, i.e. at most 6.
  - `date_in` is in 1..days(`mon_in`, year phase), where the year phase is `ymod_in` if the feature is enabled and otherwise the non-leap rule applies.
- Valid load: all state registers take the inputs.
- Invalid load: state is unchanged and `err` pulses.
- Load has priority over `tick`. When both are high, the tick is dropped and no wrap pulse is produced.
- Control states:
  - The block has one implicit state, RUN. There is no multi-cycle FSM.
  - Reset overrides both `load` and `tick` in any cycle, including mid-sequence and on a wrap cycle. Pulses produced in that cycle are suppressed.
- Width rules: all comparisons are done on zero-extended unsigned values. No output may ever hold an illegal date; the verifier asserts this continuously.

## Timing
- Every output is registered. An advance or load sampled at edge N is visible after edge N, so latency is 1 cycle.
- `month_wrap`, `year_wrap` and `err` are high for exactly the one cycle following the causing edge, coincident with the new `date_out`/`mon_out`.
- Back-to-back ticks on consecutive cycles are supported with no bubble. A pulse may therefore be followed immediately by another pulse from a following wrap, e.g. with a short-month run of loads.
- There is no handshake or backpressure. `tick` is a qualifier, not a request-acknowledge pair.
- The downstream week-teller consumes the outputs combinationally in the same cycle.

## Configuration
- Macro: `CALENDAR_LEAP_YEAR_EN`.
- Defined:
  - A 2-bit year-phase register is present and loaded from `ymod_in`.
  - Feb has 29 days when the phase is 0.
  - A load of Feb 29 is valid when `ymod_in`=0.
- Undefined:
  - There is no year-phase register, and `ymod_in` and `YEAR_MOD4_INIT` are ignored.
  - Feb always has 28 days, and loading Feb 29 raises `err`.
  - `year_wrap` still pulses.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `tick`=1 → `date_out`=1, `mon_out`=1, `week_out`=0, and all pulses 0.
- Month wrap: load 31/1/week 4, then tick → 1/2/week 5, with `month_wrap`=1 for one cycle and `year_wrap`=0.
- Leap February, with the macro defined:
  - Load 28/2/week 2 with `ymod_in`=0, then tick → 29/2/week 3.
  - Tick again → 1/3/week 4 with `month_wrap`=1.
  - Repeat with `ymod_in`=1 → 28/2 goes to 1/3.
- Year wrap: load 31/12/week 6, then tick → 1/1/week 0 with `month_wrap`=`year_wrap`=1 for one cycle.
- Invalid loads: each of the following must give `err`=1 for one cycle and an unchanged state, and a valid load of 19/10/0 afterwards must succeed with `err`=0:
  - 31/4/0
  - 0/5/0
  - 10/13/0
  - 10/5/7
- Priority and reset mid-operation:
  - `load`=1 with 15/6/3 and `tick`=1 in the same cycle → 15/6/3 with no wrap pulse.
  - Assert `rst_n`=0 on the cycle of a Dec 31 tick → 1/1/`START_WEEK` with `year_wrap`=0.
